// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Load/store engine between the EX stage and a byte-wide data
//               memory. Checks request alignment, splits accesses into
//               big-endian byte transfers (MSB at the lowest address),
//               assembles and sign/zero-extends load data, and stalls the
//               pipeline until the access retires.
// Ports       : clk, rst (async, active-low)
//               ALUResult/readData2/MemoryRead/MemoryWrite/size/
//               load_unsigned  - request from the pipeline
//               stall, done, addr_err, readDataMemory - status/result
//               mem_addr/mem_wdata/mem_we/mem_re/mem_rdata - memory port
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       readData2,
    input  logic              MemoryRead,
    input  logic              MemoryWrite,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic              stall,
    output logic              done,
    output logic              addr_err,
    output logic [31:0]       readDataMemory,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        r_idx;       // byte counter within the access
    logic [1:0]        r_last;      // N-1 for the latched size
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic              r_is_load;
    logic              r_unsigned;
    logic [31:0]       r_acc;       // load bytes shifted in MSB first

    logic              w_req;
    logic              w_illegal;
    logic [1:0]        w_last_in;
    logic [1:0]        w_idx_next;
    logic [ADDR_W-1:0] w_addr_lo;
    logic [31:0]       w_acc_next;
    logic [31:0]       w_load_ext;
    logic              w_unused_addr_hi;

    // Upper address bits lie outside the memory and are deliberately dropped.
    assign w_unused_addr_hi = ^ALUResult[31:ADDR_W];

    assign w_addr_lo  = ALUResult[ADDR_W-1:0];
    assign w_req      = MemoryRead | MemoryWrite;
    assign w_last_in  = (size == 2'd2) ? 2'd3 : ((size == 2'd1) ? 2'd1 : 2'd0);
    assign w_idx_next = r_idx + 2'd1;
    assign w_acc_next = {r_acc[23:0], mem_rdata};

    assign w_illegal = (MemoryRead & MemoryWrite)
                     | (size == 2'd3)
                     | ((size == 2'd1) & ALUResult[0])
                     | ((size == 2'd2) & (ALUResult[1:0] != 2'b00));

    assign stall = rst & (((r_state == c_ST_IDLE) & w_req)
                          | (r_state == c_ST_ACCESS)
                          | (r_state == c_ST_WAIT));

    // Final load value: the last byte arrives in WAIT, so extend from the
    // accumulator with that byte appended. Words ignore load_unsigned.
    always_comb begin
        w_load_ext = w_acc_next;
        case (r_last)
            2'd0:    w_load_ext = {{24{~r_unsigned & w_acc_next[7]}},  w_acc_next[7:0]};
            2'd1:    w_load_ext = {{16{~r_unsigned & w_acc_next[15]}}, w_acc_next[15:0]};
            default: w_load_ext = w_acc_next;
        endcase
    end

    // Byte lane sel of the store word (lane 0 = least significant).
    function automatic logic [7:0] f_pick_byte(input logic [31:0] data,
                                               input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_ST_IDLE;
            r_idx          <= 2'd0;
            r_last         <= 2'd0;
            r_base         <= '0;
            r_wdata        <= 32'd0;
            r_is_load      <= 1'b0;
            r_unsigned     <= 1'b0;
            r_acc          <= 32'd0;
            readDataMemory <= 32'd0;
            done           <= 1'b0;
            addr_err       <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= 8'd0;
            mem_we         <= 1'b0;
            mem_re         <= 1'b0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        r_base     <= w_addr_lo;
                        r_wdata    <= readData2;
                        r_last     <= w_last_in;
                        r_is_load  <= MemoryRead;
                        r_unsigned <= load_unsigned;
                        r_acc      <= 32'd0;
                        r_idx      <= 2'd0;
                        if (w_illegal) begin
                            r_state  <= c_ST_DONE;
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                        end else begin
                            // First byte strobe is issued on entry to ACCESS.
                            r_state   <= c_ST_ACCESS;
                            mem_addr  <= w_addr_lo;
                            mem_we    <= MemoryWrite;
                            mem_re    <= MemoryRead;
                            mem_wdata <= f_pick_byte(readData2, w_last_in);
                        end
                    end
                end
                c_ST_ACCESS: begin
                    // Read data lags mem_re by one cycle, so the byte for
                    // idx-1 is present while idx is being requested.
                    if (r_is_load && (r_idx != 2'd0)) begin
                        r_acc <= w_acc_next;
                    end
                    if (r_idx == r_last) begin
                        if (r_is_load) begin
                            r_state <= c_ST_WAIT;
                        end else begin
                            r_state <= c_ST_DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        r_idx     <= w_idx_next;
                        mem_addr  <= r_base + {{(ADDR_W-2){1'b0}}, w_idx_next};
                        mem_we    <= ~r_is_load;
                        mem_re    <= r_is_load;
                        mem_wdata <= f_pick_byte(r_wdata, r_last - w_idx_next);
                    end
                end
                c_ST_WAIT: begin
                    readDataMemory <= w_load_ext;
                    r_state        <= c_ST_DONE;
                    done           <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Directed cases plus
//               randomized requests compared against a byte-array reference
//               model of memory and load results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResult;
    logic [31:0] readData2;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [1:0]  size;
    logic        load_unsigned;
    logic        stall;
    logic        done;
    logic        addr_err;
    logic [31:0] readDataMemory;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .ALUResult(ALUResult), .readData2(readData2),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
        .size(size), .load_unsigned(load_unsigned),
        .stall(stall), .done(done), .addr_err(addr_err),
        .readDataMemory(readDataMemory),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the DUT, and the reference image it should match.
    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [31:0] ref_rdm;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;

    // Strobe log for the current request: relative cycle, kind, addr, data.
    int         log_cyc [$];
    bit         log_we  [$];
    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            log_cyc.push_back(cyc - t0);
            log_we.push_back(mem_we);
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // One full request from cycle 0 until retirement, checked against the model.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input bit uns);
        int          n;
        bit          ill;
        int          exp_done;
        int          d_cyc;
        int          stall_hi;
        int          nlog;
        logic [31:0] v;
        logic [31:0] mask;
        logic [7:0]  ai;
        logic [7:0]  eb;

        @(posedge clk); #1;
        ALUResult     = a;
        readData2     = d;
        MemoryRead    = rd;
        MemoryWrite   = wr;
        size          = sz;
        load_unsigned = uns;
        t0            = cyc;
        log_cyc.delete(); log_we.delete(); log_addr.delete(); log_data.delete();
        #1;
        chk("stall_c0", {31'd0, stall}, 32'd1);
        chk("done_idle", {31'd0, done}, 32'd0);

        n        = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        ill      = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                   (sz == 2'd2 && a[1:0] != 2'b00);
        exp_done = ill ? 1 : (wr ? n + 1 : n + 2);

        d_cyc    = 0;
        stall_hi = 0;
        for (int c = 1; c <= 12 && d_cyc == 0; c++) begin
            @(posedge clk); #1;
            if (done) d_cyc = c;
            else if (stall) stall_hi++;
        end
        chk("done_cyc", d_cyc, exp_done);
        if (d_cyc != 0) begin
            chk("stall_done", {31'd0, stall}, 32'd0);
            chk("stall_busy", stall_hi, exp_done - 1);
            chk("addr_err", {31'd0, addr_err}, {31'd0, ill});
        end

        // Reference model.
        if (!ill && rd) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
                ai = a[7:0] + 8'(i);
                v  = (v << 8) | {24'd0, ref_mem[ai]};
            end
            if (n < 4 && !uns && v[8*n-1]) begin
                mask = (32'd1 << (8*n)) - 32'd1;
                v    = v | ~mask;
            end
            ref_rdm = v;
        end
        if (!ill && wr) begin
            for (int i = 0; i < n; i++) begin
                ai          = a[7:0] + 8'(i);
                ref_mem[ai] = 8'(d >> (8*(n-1-i)));
            end
        end
        chk("rdata", readDataMemory, ref_rdm);

        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;

        nlog = log_cyc.size();
        chk("n_strobes", nlog, ill ? 0 : n);
        for (int i = 0; i < nlog && i < n && !ill; i++) begin
            ai = a[7:0] + 8'(i);
            chk("strb_cyc", log_cyc[i], i + 1);
            chk("strb_we", {31'd0, log_we[i]}, {31'd0, wr});
            chk("strb_addr", {24'd0, log_addr[i]}, {24'd0, ai});
            if (wr) begin
                eb = 8'(d >> (8*(n-1-i)));
                chk("strb_wdata", {24'd0, log_data[i]}, {24'd0, eb});
            end
        end
    endtask

    task automatic chk_mem_image(input string tag);
        int ndiff;
        ndiff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) ndiff++;
        chk(tag, ndiff, 0);
    endtask

    initial begin
        int done_seen;
        int r;
        int s;
        bit rd;
        bit wr;
        logic [1:0]  sz;
        logic [31:0] a;

        rst = 1'b0;
        ALUResult = 32'd0; readData2 = 32'd0;
        MemoryRead = 1'b1; MemoryWrite = 1'b0;
        size = 2'd0; load_unsigned = 1'b0;
        ref_rdm = 32'd0;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            mem[i]     = 8'(r);
            ref_mem[i] = 8'(r);
        end

        // Reset state with a request pending: no stall, all outputs zero.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdm", readDataMemory, 32'd0);
        chk("rst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        MemoryRead = 1'b0;
        @(negedge clk) rst = 1'b1;

        // Word store.
        do_req(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 0);
        chk_mem_image("mem_word_store");

        // Byte loads, signed and unsigned.
        set_mem(8'h20, 8'h80);
        do_req(1, 0, 32'h0000_0020, 32'd0, 2'd0, 0);
        chk("lb_val", readDataMemory, 32'hFFFF_FF80);
        do_req(1, 0, 32'h0000_0020, 32'd0, 2'd0, 1);
        chk("lbu_val", readDataMemory, 32'h0000_0080);

        // Half loads.
        set_mem(8'h30, 8'h12); set_mem(8'h31, 8'h34);
        do_req(1, 0, 32'h0000_0030, 32'd0, 2'd1, 0);
        chk("lh_pos", readDataMemory, 32'h0000_1234);
        set_mem(8'h30, 8'hF2);
        do_req(1, 0, 32'h0000_0030, 32'd0, 2'd1, 0);
        chk("lh_neg", readDataMemory, 32'hFFFF_F234);

        // Illegal requests.
        do_req(1, 0, 32'h0000_0011, 32'd0, 2'd1, 0);
        do_req(0, 1, 32'h0000_0022, 32'h1122_3344, 2'd2, 0);
        do_req(1, 0, 32'h0000_0040, 32'd0, 2'd3, 0);
        do_req(1, 1, 32'h0000_0040, 32'h5566_7788, 2'd0, 0);
        chk("rdm_after_err", readDataMemory, 32'hFFFF_F234);
        chk_mem_image("mem_after_err");

        // Top of memory with junk in the upper address bits.
        set_mem(8'hFC, 8'hA1); set_mem(8'hFD, 8'hB2);
        set_mem(8'hFE, 8'hC3); set_mem(8'hFF, 8'hD4);
        do_req(1, 0, 32'hABCD_E0FC, 32'd0, 2'd2, 1);
        chk("top_word", readDataMemory, 32'hA1B2_C3D4);

        // Reset during a word store, in cycle 2.
        @(posedge clk); #1;
        ALUResult = 32'h0000_0050; readData2 = 32'hCAFE_F00D;
        MemoryWrite = 1'b1; size = 2'd2; load_unsigned = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_outs", {29'd0, done, addr_err, |mem_addr}, 32'd0);
        chk("midrst_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("midrst_rdm", readDataMemory, 32'd0);
        MemoryWrite = 1'b0;
        ref_mem[8'h50] = 8'hCA;   // only the cycle-1 byte reached memory
        ref_rdm = 32'd0;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);
        chk_mem_image("mem_after_rst");
        do_req(1, 0, 32'h0000_0050, 32'd0, 2'd0, 1);
        chk("post_rst_lbu", readDataMemory, 32'h0000_00CA);

        // Randomized requests, back to back.
        for (int k = 0; k < 300; k++) begin
            r  = $urandom_range(0, 19);
            rd = (r == 0) || (r < 10);
            wr = (r == 0) || (r >= 10);
            s  = $urandom_range(0, 9);
            sz = (s < 3) ? 2'd0 : ((s < 6) ? 2'd1 : ((s < 9) ? 2'd2 : 2'd3));
            a  = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(rd, wr, a, $urandom, sz, 1'($urandom));
        end
        chk_mem_image("mem_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sits between the EX stage and the byte-wide data memory of the MIPS datapath. Takes a load or store request (address from `ALUResult`, store data from `readData2`) and checks alignment. Splits the access into big-endian byte transfers on the memory port, and assembles and sign/zero-extends load results. Stalls the pipeline until the access completes.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of the data memory (256 bytes); upper `ALUResult` bits ignored

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ALUResult  in  32  effective byte address
- readData2  in  32  store data; the low 1/2/4 bytes are used
- MemoryRead  in  1  load request
- MemoryWrite  in  1  store request
- size  in  2  0=byte, 1=half, 2=word, 3=illegal
- load_unsigned  in  1  1=zero-extend, 0=sign-extend (LBU/LHU vs LB/LH)
- stall  out  1  hold pipeline (combinational)
- done  out  1  one-cycle pulse, request retired
- addr_err  out  1  one-cycle pulse with done, request rejected
- readDataMemory  out  32  extended load result, held until next load completes
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  8  write byte
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  8  read byte, valid the cycle after mem_re

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- A request exists when MemoryRead or MemoryWrite is high in IDLE. It is sampled at that edge: base address, store data, size, type, and extension are latched.
- N = 1/2/4 for byte/half/word.
- Error path: the request is illegal if any of these holds:
  - MemoryRead and MemoryWrite are both high.
  - size=3.
  - A half access has addr[0]≠0.
  - A word access has addr[1:0]≠0.
- An illegal request goes IDLE→DONE with addr_err=1 and issues no memory strobes.
- ACCESS: byte counter idx runs 0..N-1, one byte per cycle, and mem_addr = base+idx (ADDR_W bits).
  - Big-endian ordering: idx 0 carries the most significant byte of the access.
  - Store: mem_we=1 and mem_wdata = store byte (N-1-idx). After idx=N-1, go to DONE.
  - Load: mem_re=1. Each returned byte shifts into an accumulator, MSB first. After idx=N-1, go to WAIT.
- WAIT (loads only): capture the last byte, then go to DONE.
- Load result in DONE: bit 8N-1 is replicated into bits 31..8N unless load_unsigned is set. For a word, load_unsigned is ignored.
- DONE: done=1 and stall=0.
  - For a load, readDataMemory updates at the edge entering DONE.
  - Stores and errors leave readDataMemory unchanged.
  - DONE never accepts a new request; it always returns to IDLE.
- stall = rst & ((state==IDLE & request) | state==ACCESS | state==WAIT).
- The pipeline holds all request inputs stable while stall=1.

## Timing
- Cycle 0 = IDLE with request present (stall=1).
- Store: ACCESS in cycles 1..N, DONE in cycle N+1. Occupancy is N+2 cycles.
- Load: mem_re in cycles 1..N, WAIT in cycle N+1, DONE in cycle N+2. readDataMemory is valid from cycle N+2.
- Error: DONE in cycle 1.
- Strobes are registered outputs, decoded from state and idx only. They are never high outside ACCESS.
- Reset (rst=0) is asynchronous:
  - State goes to IDLE and idx to 0.
  - readDataMemory, done, addr_err, mem_addr, mem_wdata, mem_we, mem_re all go to 0.
  - stall=0 while rst=0.
  - Reset mid-access aborts immediately. Partially written bytes stay in memory, and no done is issued.
- Back-to-back: a new request is first seen in the cycle after DONE.
- No address wrap beyond ADDR_W occurs for aligned accesses, because base+N-1 ≤ 2^ADDR_W-1.

## Test plan
- Word store: ALUResult=0x10, readData2=0xDEADBEEF, size=2.
  - Required: mem_we in cycles 1-4 writing DE,AD,BE,EF to 0x10-0x13.
  - Required: done in cycle 5, stall low from cycle 5.
- Signed byte load: memory[0x20]=0x80, size=0, load_unsigned=0.
  - Required: mem_re in cycle 1 only, done in cycle 3, readDataMemory=0xFFFFFF80.
  - Repeat with load_unsigned=1: required readDataMemory=0x00000080.
- Half load: memory 0x30/0x31 = 0x12/0x34, size=1, signed.
  - Required: readDataMemory=0x00001234, done in cycle 4.
  - Repeat with memory 0x30/0x31 = 0xF2/0x34: required 0xFFFFF234.
- Misaligned/illegal requests:
  - Half at 0x11 → addr_err=done=1 in cycle 1, no strobes, readDataMemory unchanged.
  - Same for word at 0x22, size=3, and MemoryRead=MemoryWrite=1.
- Top of memory: word load at 0xFC with ALUResult upper bits = 0xABCDE.
  - Required: addresses 0xFC-0xFF only.
  - Required: result = bytes 0xFC..0xFF concatenated.
- Reset during word store: drop rst in cycle 2.
  - Required: all strobes and outputs 0 immediately, no done.
  - Required: after release, the next byte load completes normally.
